// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller owning HI/LO, sequencing
// multi-cycle mult/div and raising a stall for MDU-dependent D-stage ops.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]  r_hi, r_lo, r_phi, r_plo;
    logic         r_skip;

    logic         w_start, w_is_div;
    logic [63:0]  w_smul, w_umul, w_res;
    logic [31:0]  w_ars, w_art, w_aq, w_ar, w_sq, w_sr, w_uq, w_ur;

    assign w_is_div = (e_op == 4'd3) || (e_op == 4'd4);
    assign w_start  = (r_state == IDLE) && (e_op >= 4'd1) && (e_op <= 4'd4);

    assign w_smul = $signed({{32{e_rs[31]}}, e_rs}) * $signed({{32{e_rt[31]}}, e_rt});
    assign w_umul = {32'd0, e_rs} * {32'd0, e_rt};

    // Signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign w_ars = e_rs[31] ? -e_rs : e_rs;
    assign w_art = e_rt[31] ? -e_rt : e_rt;
    assign w_aq  = w_ars / w_art;
    assign w_ar  = w_ars % w_art;
    assign w_sq  = (e_rs[31] ^ e_rt[31]) ? -w_aq : w_aq;
    assign w_sr  = e_rs[31] ? -w_ar : w_ar;
    assign w_uq  = e_rs / e_rt;
    assign w_ur  = e_rs % e_rt;

    assign w_res = (e_op == 4'd1) ? w_smul :
                   (e_op == 4'd2) ? w_umul :
                   (e_op == 4'd3) ? {w_sr, w_sq} : {w_ur, w_uq};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_skip  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_start) begin
                {r_phi, r_plo} <= w_res;
                r_skip  <= w_is_div && (e_rt == 32'd0);
                r_cnt   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                r_state <= RUN;
            end else if (e_op == 4'd7) begin
                r_hi <= e_rs;
            end else if (e_op == 4'd8) begin
                r_lo <= e_rs;
            end
        end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_state <= IDLE;
                if (!r_skip) begin
                    r_hi <= r_phi;
                    r_lo <= r_plo;
                end
            end
        end
    end

    assign busy    = (r_state == RUN);
    assign stall   = d_uses_md && (w_start || busy);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign rd_data = (e_op == 4'd5) ? r_hi : (e_op == 4'd6) ? r_lo : 32'd0;
endmodule
